// File: rtl/mem_access_unit.sv
// MEM-stage bus sequencer: issues one lane-aligned load/store per instruction
// on a valid/ready request channel, waits for the memory response, and returns
// the extended load result (or a misaligned / bus-timeout flag) with done.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [3:0]        strobe,
  output logic              stall,
  output logic              done,
  output logic [31:0]       load_data,
  output logic              misaligned,
  output logic              bus_err,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  output logic              req_we,
  output logic [3:0]        req_wstrb,
  output logic [31:0]       req_wdata,
  input  logic              resp_valid,
  input  logic [31:0]       resp_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        f3_q;
  logic              st_q;
  logic [31:0]       wdata_q;
  logic [3:0]        strb_q;
  logic [31:0]       cnt;
  logic              timeout;
  logic [31:0]       shifted;
  logic [31:0]       ext;

  // Counter reaching its last allowed cycle ends the access with bus_err.
  // The >= keeps a late handshake in the final REQ cycle from escaping.
  assign timeout = TO_EN && (cnt >= TO_LAST);

  assign stall     = mem_valid & ~done;
  assign done      = (state == S_DONE);
  assign req_valid = (state == S_REQ);
  assign req_we    = req_valid & st_q;
  assign req_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign req_wstrb = strb_q;
  assign req_wdata = wdata_q;

  // Pull the addressed lanes down to bit 0 and extend per funct3.
  always_comb begin
    shifted = resp_rdata >> {addr_q[1:0], 3'b000};
    ext     = shifted;
    case (f3_q)
      3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  ext = {24'd0, shifted[7:0]};
      3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  ext = {16'd0, shifted[15:0]};
      default: ext = shifted;
    endcase
  end

  // Sequencer: accept, request, wait for response/ack, one-cycle done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      addr_q     <= '0;
      f3_q       <= '0;
      st_q       <= 1'b0;
      wdata_q    <= '0;
      strb_q     <= '0;
      cnt        <= '0;
      load_data  <= '0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mem_valid) begin
            addr_q  <= addr;
            f3_q    <= funct3;
            st_q    <= is_store;
            wdata_q <= wdata;
            strb_q  <= strobe;
            cnt     <= '0;
            if (strobe == 4'd0) begin
              misaligned <= 1'b1;
              state      <= S_DONE;
            end else begin
              state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (TO_EN) cnt <= cnt + 32'd1;
          if (req_ready) begin
            state <= S_RESP;
          end else if (timeout) begin
            bus_err <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_RESP: begin
          if (TO_EN) cnt <= cnt + 32'd1;
          if (resp_valid) begin
            load_data <= st_q ? 32'd0 : ext;
            state     <= S_DONE;
          end else if (timeout) begin
            bus_err <= 1'b1;
            state   <= S_DONE;
          end
        end
        default: begin
          load_data  <= '0;
          misaligned <= 1'b0;
          bus_err    <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic [3:0]  strobe;
  logic        stall, done, misaligned, bus_err;
  logic [31:0] load_data;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic [31:0] resp_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  mem_access_unit #(.TIMEOUT_CYCLES(8), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .is_store(is_store),
    .funct3(funct3), .addr(addr), .wdata(wdata), .strobe(strobe),
    .stall(stall), .done(done), .load_data(load_data),
    .misaligned(misaligned), .bus_err(bus_err),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bad(input string tag);
    n_fail++;
    $error("FAIL %s", tag);
  endtask

  task automatic load_zw(input logic [31:0] a, input logic [2:0] f3,
                         input logic [3:0] sb, input logic [31:0] rd,
                         input logic [31:0] exp, input string tag);
    mem_valid = 1; is_store = 0; funct3 = f3; addr = a; strobe = sb;
    req_ready = 1; resp_valid = 0;
    cyc();
    cyc();
    resp_valid = 1; resp_rdata = rd;
    cyc();
    resp_valid = 0;
    #1;
    n_tests++; if (done !== 1'b1) bad({tag, "_done"});
    n_tests++; if (load_data !== exp) bad({tag, "_data"});
    mem_valid = 0;
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; mem_valid = 0; is_store = 0; funct3 = 0; addr = 0; wdata = 0;
    strobe = 0; req_ready = 0; resp_valid = 0; resp_rdata = 0;
    cyc(); cyc();
    #1;
    n_tests++; if (done !== 1'b0) bad("rst_done");
    n_tests++; if (stall !== 1'b0) bad("rst_stall");
    n_tests++; if (req_valid !== 1'b0) bad("rst_req_valid");
    n_tests++; if (req_addr !== 32'h0) bad("rst_req_addr");
    n_tests++; if (load_data !== 32'h0) bad("rst_load_data");
    n_tests++; if ({misaligned, bus_err, req_we} !== 3'b000) bad("rst_flags");
    rst = 0;
    cyc();

    mem_valid = 1; funct3 = 3'b010; addr = 32'h100; strobe = 4'hF; req_ready = 1;
    #1;
    n_tests++; if (stall !== 1'b1) bad("wl_c1_stall");
    n_tests++; if (req_valid !== 1'b0) bad("wl_c1_req_valid");
    cyc();
    #1;
    n_tests++; if (req_valid !== 1'b1) bad("wl_c2_req_valid");
    n_tests++; if (req_addr !== 32'h100) bad("wl_c2_req_addr");
    n_tests++; if (req_we !== 1'b0) bad("wl_c2_req_we");
    n_tests++; if (stall !== 1'b1) bad("wl_c2_stall");
    cyc();
    resp_valid = 1; resp_rdata = 32'hDEADBEEF;
    #1;
    n_tests++; if (req_valid !== 1'b0) bad("wl_c3_req_valid");
    n_tests++; if (stall !== 1'b1) bad("wl_c3_stall");
    n_tests++; if (done !== 1'b0) bad("wl_c3_done");
    cyc();
    resp_valid = 0;
    #1;
    n_tests++; if (done !== 1'b1) bad("wl_c4_done");
    n_tests++; if (load_data !== 32'hDEADBEEF) bad("wl_c4_data");
    n_tests++; if (stall !== 1'b0) bad("wl_c4_stall");
    mem_valid = 0;
    cyc();
    #1;
    n_tests++; if (done !== 1'b0) bad("wl_c5_done");
    n_tests++; if (load_data !== 32'h0) bad("wl_c5_data_clr");

    load_zw(32'h103, 3'b000, 4'b1000, 32'h80123456, 32'hFFFFFF80, "lb3");
    load_zw(32'h103, 3'b100, 4'b1000, 32'h80123456, 32'h00000080, "lbu3");
    load_zw(32'h102, 3'b001, 4'b1100, 32'h9ABC0000, 32'hFFFF9ABC, "lh2");
    load_zw(32'h102, 3'b101, 4'b1100, 32'h9ABC0000, 32'h00009ABC, "lhu2");
    load_zw(32'h101, 3'b000, 4'b0010, 32'h00007F00, 32'h0000007F, "lb1_pos");

    mem_valid = 1; is_store = 1; funct3 = 3'b000; addr = 32'h201;
    strobe = 4'b0010; wdata = 32'h0000AB00; req_ready = 0;
    cyc();
    addr = 32'hFFF; wdata = 32'h12345678; strobe = 4'b0001; is_store = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) req_ready = 1;
      #1;
      n_tests++; if (req_valid !== 1'b1) bad("st_req_valid");
      n_tests++; if (req_addr !== 32'h200) bad("st_req_addr");
      n_tests++; if (req_we !== 1'b1) bad("st_req_we");
      n_tests++; if (req_wstrb !== 4'b0010) bad("st_req_wstrb");
      n_tests++; if (req_wdata !== 32'h0000AB00) bad("st_req_wdata");
      cyc();
    end
    req_ready = 0;
    #1;
    n_tests++; if (req_valid !== 1'b0) bad("st_resp_wait_valid");
    cyc();
    #1;
    n_tests++; if (done !== 1'b0) bad("st_resp_wait_done");
    resp_valid = 1; resp_rdata = 32'hFFFFFFFF;
    cyc();
    resp_valid = 0;
    #1;
    n_tests++; if (done !== 1'b1) bad("st_done");
    n_tests++; if (load_data !== 32'h0) bad("st_data");
    mem_valid = 0;
    cyc();

    mem_valid = 1; is_store = 0; funct3 = 3'b010; addr = 32'h302; strobe = 4'b0000;
    req_ready = 1;
    #1;
    n_tests++; if (req_valid !== 1'b0) bad("mis_c1_req_valid");
    cyc();
    #1;
    n_tests++; if (req_valid !== 1'b0) bad("mis_c2_req_valid");
    n_tests++; if (done !== 1'b1) bad("mis_c2_done");
    n_tests++; if (misaligned !== 1'b1) bad("mis_c2_misaligned");
    n_tests++; if (bus_err !== 1'b0) bad("mis_c2_bus_err");
    mem_valid = 0;
    cyc();
    #1;
    n_tests++; if ({done, misaligned} !== 2'b00) bad("mis_c3_clr");

    mem_valid = 1; funct3 = 3'b010; addr = 32'h400; strobe = 4'hF; req_ready = 1;
    cyc();
    req_ready = 0;
    for (int i = 0; i < 7; i++) cyc();
    #1;
    n_tests++; if (done !== 1'b0) bad("to_c9_done");
    cyc();
    #1;
    n_tests++; if (done !== 1'b1) bad("to_done");
    n_tests++; if (bus_err !== 1'b1) bad("to_bus_err");
    n_tests++; if (load_data !== 32'h0) bad("to_data");
    mem_valid = 0; resp_valid = 1; resp_rdata = 32'h55555555;
    cyc();
    #1;
    n_tests++; if (done !== 1'b0) bad("to_late_done");
    n_tests++; if (bus_err !== 1'b0) bad("to_late_err_clr");
    cyc();
    resp_valid = 0;
    #1;
    n_tests++; if ({done, req_valid} !== 2'b00) bad("to_late_req");

    mem_valid = 1; funct3 = 3'b010; addr = 32'h500; strobe = 4'hF; req_ready = 1;
    cyc();
    resp_valid = 1; resp_rdata = 32'h11111111;
    cyc();
    resp_rdata = 32'h22222222;
    #1;
    n_tests++; if (done !== 1'b0) bad("sim_c3_done");
    cyc();
    resp_valid = 0;
    #1;
    n_tests++; if (done !== 1'b1) bad("sim_done");
    n_tests++; if (load_data !== 32'h22222222) bad("sim_data");
    mem_valid = 0;
    cyc();

    mem_valid = 1; funct3 = 3'b010; addr = 32'h600; strobe = 4'hF; req_ready = 1;
    cyc();
    req_ready = 0;
    cyc();
    rst = 1; mem_valid = 0;
    cyc();
    rst = 0;
    #1;
    n_tests++; if (req_valid !== 1'b0) bad("rr_req_valid");
    n_tests++; if (done !== 1'b0) bad("rr_done");
    resp_valid = 1; resp_rdata = 32'h77777777;
    cyc();
    #1;
    n_tests++; if (done !== 1'b0) bad("rr_late_done");
    n_tests++; if (load_data !== 32'h0) bad("rr_late_data");
    resp_valid = 0;
    cyc();
    #1;
    n_tests++; if ({done, req_valid, stall} !== 3'b000) bad("rr_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage bus sequencer for the in-order pipeline; sits directly downstream of the load/store byte-lane decoder.
- Accepts one load or store per instruction, already lane-aligned with a byte strobe. Drives a valid/ready request channel and a response channel to data memory.
- Stalls the pipeline until the access completes.
- Returns the load result extracted from the addressed lanes and sign/zero-extended, or flags misalignment or bus timeout.

Parameters:
TIMEOUT_CYCLES, 64, cycles allowed in REQ+RESP before bus error; 0 disables the timeout
ADDR_W, 32, byte address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
mem_valid  in  1  MEM stage holds a memory op; held stable until done
is_store  in  1  1=store, 0=load (meaningful when mem_valid)
funct3  in  3  RV32 load/store funct3
addr  in  ADDR_W  byte address
wdata  in  32  lane-aligned store data
strobe  in  4  byte-lane strobe; 0 means misaligned/illegal
stall  out  1  pipeline stall request
done  out  1  one-cycle completion pulse
load_data  out  32  extended load result, valid with done
misaligned  out  1  with done: access not issued, strobe was 0
bus_err  out  1  with done: timeout expired
req_valid  out  1  bus request valid
req_ready  in  1  bus accepts request
req_addr  out  ADDR_W  word address, low 2 bits forced 0
req_we  out  1  write enable
req_wstrb  out  4  byte strobe
req_wdata  out  32  write data
resp_valid  in  1  response/ack from memory
resp_rdata  in  32  read word

Behaviour:
- Reset values: state IDLE; stall, done, misaligned, bus_err, req_valid, req_we = 0; req_addr, req_wstrb, req_wdata, load_data = 0; timeout counter 0.
- stall = mem_valid & ~done, combinational.
- States: IDLE, REQ, RESP, DONE.
- IDLE, mem_valid=1, strobe!=0:
  - Latch addr, addr[1:0], funct3, is_store, wdata, strobe.
  - Go to REQ.
- IDLE, mem_valid=1, strobe=0:
  - Set misaligned flag; go to DONE. No bus request is issued.
- IDLE, mem_valid=0: stay in IDLE.
- REQ:
  - req_valid=1; req_addr={addr[ADDR_W-1:2],2'b00}; req_we=is_store; req_wstrb/req_wdata from latches.
  - All request outputs stay stable until the handshake completes.
  - On req_valid & req_ready (same cycle): go to RESP; req_valid=0 from the next cycle.
- RESP:
  - Wait for resp_valid; stores also wait for it (write ack).
  - On resp_valid, latch the result and go to DONE.
  - Load result: shift resp_rdata right by 8*addr[1:0], then apply funct3:
    - 000: sign-extend bits[7:0]
    - 100: zero-extend bits[7:0]
    - 001: sign-extend bits[15:0]
    - 101: zero-extend bits[15:0]
    - 010: full word
  - Stores return load_data=0.
- DONE:
  - done=1 for exactly one cycle, together with load_data and the misaligned/bus_err flags.
  - Return to IDLE.
  - A new op may be accepted in the following IDLE cycle, giving a minimum 4-cycle load with zero-wait memory.
  - Flags and load_data clear to 0 when leaving DONE.
- Timeout:
  - Counter clears on entry to REQ and increments each cycle in REQ or RESP.
  - At TIMEOUT_CYCLES: set bus_err, drop req_valid, go to DONE, load_data=0.
  - With TIMEOUT_CYCLES=0 the unit waits indefinitely.
- Ignored inputs:
  - resp_valid in IDLE, REQ or DONE, including late responses after a timeout or reset.
  - req_ready outside REQ.
  - Input changes after acceptance; only latched values are used.
- Simultaneous events: req_ready and resp_valid in the same REQ cycle. The response is not taken; the memory must respond in a later cycle.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. req_valid drops in the cycle after rst is sampled high.

Test Plan:
- Word load, zero-wait: addr=0x100, funct3=010, strobe=1111, req_ready=1, resp_rdata=0xDEADBEEF the cycle after the handshake -> req_addr=0x100, req_we=0; done pulses on cycle 4 with load_data=0xDEADBEEF; stall high for cycles 1-3.
- Byte loads, lane 3: resp_rdata=0x80123456, addr=0x103, strobe=1000 -> funct3=000 gives load_data=0xFFFFFF80; funct3=100 gives 0x00000080.
- Half loads, upper lane: resp_rdata=0x9ABC0000, addr=0x102 -> funct3=001 gives 0xFFFF9ABC; funct3=101 gives 0x00009ABC.
- Store with backpressure: addr=0x201, strobe=0010, wdata=0x0000AB00; req_ready low for 3 cycles -> request outputs stable throughout; req_addr=0x200, req_we=1, req_wstrb=0010; done follows resp_valid with load_data=0.
- Misaligned: strobe=0000 -> req_valid never asserts; done and misaligned pulse on cycle 2.
- Timeout and reset: TIMEOUT_CYCLES=8, resp_valid never asserted -> bus_err with done after 8 cycles in REQ/RESP; a late resp_valid is ignored. Separately, rst asserted while in RESP -> IDLE, req_valid=0, no done pulse.
